// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the fetch, load/store and memory-port signals of the shared
// single-port memory arbiter.
//   slave  : the arbiter's view (takes requests and read data, drives acks and the port)
//   master : the requesters' and memory's view
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;

  logic        dm_req;
  logic        dm_wen;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  modport slave (
    input  if_req, if_addr, dm_req, dm_wen, dm_addr, dm_wdata, mem_dout,
    output if_ack, if_rdata, dm_ack, dm_rdata, mem_ren, mem_wen, mem_addr, mem_din
  );

  modport master (
    output if_req, if_addr, dm_req, dm_wen, dm_addr, dm_wdata, mem_dout,
    input  if_ack, if_rdata, dm_ack, dm_rdata, mem_ren, mem_wen, mem_addr, mem_din
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Grants the shared single-port memory to either instruction fetch (IF) or
// load/store (DM) each cycle. The grant register is the only source of the
// port mux; acks and read data follow the grant combinationally.
// Optional feature macro: MEM_ARB_STARVE_EN
//   defined   -> after STARVE_LIMIT consecutive DM grants taken while fetch
//                waits, the next contended cycle is forced to IF.
//   undefined -> strict DM-over-IF priority, STARVE_LIMIT has no effect.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clock,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_DM   = 2'd2
  } gnt_t;

  gnt_t        gnt_r;
  gnt_t        gnt_next_s;
  logic        starve_hit_s;

  logic        if_ack_s;
  logic [31:0] if_rdata_s;
  logic        dm_ack_s;
  logic [31:0] dm_rdata_s;
  logic        mem_ren_s;
  logic        mem_wen_s;
  logic [31:0] mem_addr_s;
  logic [31:0] mem_din_s;

  // A limit outside the 4-bit counter range can never be matched; stop the build.
  if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : g_limit_range
    $error("mem_port_arbiter: STARVE_LIMIT must be within 1..15");
  end

`ifdef MEM_ARB_STARVE_EN
  localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt_r;
  logic [3:0] starve_cnt_next_s;

  // Fetch is forced once DM has won LIMIT_C times in a row against it.
  assign starve_hit_s = (starve_cnt_r == LIMIT_C);

  // Count DM grants being taken while fetch is waiting; anything else clears.
  always_comb begin
    starve_cnt_next_s = 4'd0;
    if (bus.if_req && (gnt_next_s == GNT_DM)) begin
      if (starve_cnt_r >= LIMIT_C) begin
        starve_cnt_next_s = LIMIT_C;
      end else begin
        starve_cnt_next_s = starve_cnt_r + 4'd1;
      end
    end else begin
      starve_cnt_next_s = 4'd0;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt_r <= 4'd0;
    end else begin
      starve_cnt_r <= starve_cnt_next_s;
    end
  end
`else
  assign starve_hit_s = 1'b0;
`endif

  // Grant register: reset aborts any access in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      gnt_r <= GNT_IDLE;
    end else begin
      gnt_r <= gnt_next_s;
    end
  end

  // Next grant from the requests seen at this edge; DM wins ties unless fetch is starving.
  always_comb begin
    gnt_next_s = GNT_IDLE;
    case ({bus.if_req, bus.dm_req})
      2'b00:   gnt_next_s = GNT_IDLE;
      2'b10:   gnt_next_s = GNT_IF;
      2'b01:   gnt_next_s = GNT_DM;
      2'b11: begin
        if (starve_hit_s) begin
          gnt_next_s = GNT_IF;
        end else begin
          gnt_next_s = GNT_DM;
        end
      end
      default: gnt_next_s = GNT_IDLE;
    endcase
  end

  // Port mux and acks driven from the current grant; everything not granted reads 0.
  always_comb begin
    if_ack_s   = 1'b0;
    if_rdata_s = 32'd0;
    dm_ack_s   = 1'b0;
    dm_rdata_s = 32'd0;
    mem_ren_s  = 1'b0;
    mem_wen_s  = 1'b0;
    mem_addr_s = 32'd0;
    mem_din_s  = 32'd0;
    case (gnt_r)
      GNT_IF: begin
        mem_ren_s  = 1'b1;
        mem_addr_s = bus.if_addr;
        if_ack_s   = 1'b1;
        if_rdata_s = bus.mem_dout;
      end
      GNT_DM: begin
        mem_addr_s = bus.dm_addr;
        mem_din_s  = bus.dm_wdata;
        mem_ren_s  = ~bus.dm_wen;
        mem_wen_s  = bus.dm_wen;
        dm_ack_s   = 1'b1;
        if (bus.dm_wen) begin
          dm_rdata_s = 32'd0;
        end else begin
          dm_rdata_s = bus.mem_dout;
        end
      end
      GNT_IDLE: begin
        mem_addr_s = 32'd0;
      end
      default: begin
        mem_addr_s = 32'd0;
      end
    endcase
  end

  assign bus.if_ack   = if_ack_s;
  assign bus.if_rdata = if_rdata_s;
  assign bus.dm_ack   = dm_ack_s;
  assign bus.dm_rdata = dm_rdata_s;
  assign bus.mem_ren  = mem_ren_s;
  assign bus.mem_wen  = mem_wen_s;
  assign bus.mem_addr = mem_addr_s;
  assign bus.mem_din  = mem_din_s;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Drives mem_port_arbiter as both requesters and as the shared memory.
// Inputs change just after the falling edge (after any store has committed),
// outputs are sampled 2 time units after the rising edge.
module tb_mem_port_arbiter;

  localparam int TB_LIMIT = 4;

  logic clock;
  logic reset;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.STARVE_LIMIT(TB_LIMIT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Memory seen by the DUT, and the bench's own shadow copy for predictions.
  logic [31:0] tb_mem  [0:255];
  logic [31:0] ref_mem [0:255];

  assign bus.mem_dout = tb_mem[bus.mem_addr[7:0]];

  // Memory writes on the falling edge, blocked while reset is asserted.
  always @(negedge clock) begin
    if (reset && bus.mem_wen) begin
      tb_mem[bus.mem_addr[7:0]] <= bus.mem_din;
    end
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Model history: one entry per past cycle, 1 when DM was granted while fetch waited.
  bit hist[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Number of most recent consecutive cycles in which DM beat a waiting fetch.
  function automatic int dm_streak();
    int n;
    n = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (!hist[i]) break;
      n++;
    end
    return n;
  endfunction

  // One clock cycle: present requests, predict the grant, compare all outputs.
  // g: 0 none, 1 fetch, 2 data. acks_got = {dm_ack, if_ack}.
  task automatic run_cycle(input logic ir, input logic [31:0] ia,
                           input logic dr, input logic dw,
                           input logic [31:0] da, input logic [31:0] dd,
                           output logic [1:0] acks_got, output logic [31:0] rd_got,
                           output logic wen_got);
    int g;
    logic [31:0] e_if_rd, e_dm_rd, e_addr, e_din;
    logic e_ren, e_wen;
    bus.if_req   = ir;
    bus.if_addr  = ia;
    bus.dm_req   = dr;
    bus.dm_wen   = dw;
    bus.dm_addr  = da;
    bus.dm_wdata = dd;
    @(posedge clock);
    if (ir && dr) begin
`ifdef MEM_ARB_STARVE_EN
      g = (dm_streak() >= TB_LIMIT) ? 1 : 2;
`else
      g = 2;
`endif
    end else if (ir) begin
      g = 1;
    end else if (dr) begin
      g = 2;
    end else begin
      g = 0;
    end
    hist.push_back((g == 2) && ir);
    if (hist.size() > 20) void'(hist.pop_front());
    e_if_rd = 32'd0; e_dm_rd = 32'd0; e_addr = 32'd0; e_din = 32'd0;
    e_ren = 1'b0; e_wen = 1'b0;
    if (g == 1) begin
      e_ren = 1'b1; e_addr = ia; e_if_rd = ref_mem[ia[7:0]];
    end else if (g == 2) begin
      e_addr = da; e_din = dd; e_ren = ~dw; e_wen = dw;
      e_dm_rd = dw ? 32'd0 : ref_mem[da[7:0]];
    end
    #2;
    chk("if_ack",   32'(bus.if_ack),  32'(g == 1));
    chk("dm_ack",   32'(bus.dm_ack),  32'(g == 2));
    chk("mem_ren",  32'(bus.mem_ren), 32'(e_ren));
    chk("mem_wen",  32'(bus.mem_wen), 32'(e_wen));
    chk("mem_addr", bus.mem_addr, e_addr);
    chk("mem_din",  bus.mem_din,  e_din);
    chk("if_rdata", bus.if_rdata, e_if_rd);
    chk("dm_rdata", bus.dm_rdata, e_dm_rd);
    acks_got = {bus.dm_ack, bus.if_ack};
    rd_got   = bus.if_rdata | bus.dm_rdata;
    wen_got  = bus.mem_wen;
    if ((g == 2) && dw) ref_mem[da[7:0]] = dd;
    @(negedge clock);
    #1;
  endtask

  typedef struct {
    string       name;
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [31:0] dd;
    logic [1:0]  e_acks;
    logic [31:0] e_rd;
    logic        e_wen;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input logic ir, input logic [31:0] ia,
                     input logic dr, input logic dw, input logic [31:0] da,
                     input logic [31:0] dd, input logic [1:0] ea,
                     input logic [31:0] erd, input logic ewen);
    vec_t v;
    v.name = nm; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
    v.e_acks = ea; v.e_rd = erd; v.e_wen = ewen;
    vecs.push_back(v);
  endtask

  initial begin
    logic [1:0]  acks;
    logic [31:0] rd;
    logic        wen;

    for (int i = 0; i < 256; i++) begin
      tb_mem[i]  = 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
      ref_mem[i] = 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
    end
    tb_mem[5]  = 32'h0000_1234;
    ref_mem[5] = 32'h0000_1234;

    // Reset state
    reset = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = 32'd0;
    bus.dm_req = 1'b0; bus.dm_wen = 1'b0; bus.dm_addr = 32'd0; bus.dm_wdata = 32'd0;
    #3;
    chk("rst_acks",  32'({bus.dm_ack, bus.if_ack}), 32'd0);
    chk("rst_en",    32'({bus.mem_wen, bus.mem_ren}), 32'd0);
    chk("rst_addr",  bus.mem_addr, 32'd0);
    chk("rst_din",   bus.mem_din, 32'd0);
    chk("rst_rdata", bus.if_rdata | bus.dm_rdata, 32'd0);
    @(negedge clock);
    #1;
    reset = 1'b1;

    // Directed table
    for (int i = 0; i < 3; i++)
      add("fetch", 1'b1, 32'd5, 1'b0, 1'b0, 32'd0, 32'd0, 2'b01, 32'h0000_1234, 1'b0);
    add("idle1", 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 32'd0, 1'b0);
    add("store", 1'b0, 32'd0, 1'b1, 1'b1, 32'd8, 32'hDEAD_BEEF, 2'b10, 32'd0, 1'b1);
    add("load",  1'b0, 32'd0, 1'b1, 1'b0, 32'd8, 32'd0, 2'b10, 32'hDEAD_BEEF, 1'b0);
    add("idle2", 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 32'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
`ifdef MEM_ARB_STARVE_EN
      if ((i % 5) == 4)
        add("contend", 1'b1, 32'd5, 1'b1, 1'b0, 32'd8, 32'd0, 2'b01, 32'h0000_1234, 1'b0);
      else
        add("contend", 1'b1, 32'd5, 1'b1, 1'b0, 32'd8, 32'd0, 2'b10, 32'hDEAD_BEEF, 1'b0);
`else
      add("contend", 1'b1, 32'd5, 1'b1, 1'b0, 32'd8, 32'd0, 2'b10, 32'hDEAD_BEEF, 1'b0);
`endif
    end
    add("idle3",  1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 32'd0, 1'b0);
    add("cancel", 1'b1, 32'd7, 1'b1, 1'b1, 32'd9, 32'h0BAD_CAFE, 2'b10, 32'd0, 1'b1);
    add("dropped", 1'b0, 32'd7, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 32'd0, 1'b0);
    add("idle4",  1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 32'd0, 1'b0);

    foreach (vecs[i]) begin
      run_cycle(vecs[i].ir, vecs[i].ia, vecs[i].dr, vecs[i].dw, vecs[i].da, vecs[i].dd,
                acks, rd, wen);
      chk({vecs[i].name, "_acks"},  32'(acks), 32'(vecs[i].e_acks));
      chk({vecs[i].name, "_rdata"}, rd, vecs[i].e_rd);
      chk({vecs[i].name, "_wen"},   32'(wen), 32'(vecs[i].e_wen));
    end
    chk("store_mem8", tb_mem[8], 32'hDEAD_BEEF);

    // Reset in the middle of a store grant: outputs drop at once, no write lands
    bus.if_req = 1'b0;
    bus.dm_req = 1'b1; bus.dm_wen = 1'b1; bus.dm_addr = 32'd20; bus.dm_wdata = 32'hCAFE_F00D;
    @(posedge clock);
    #2;
    chk("rstmid_pre_wen", 32'(bus.mem_wen), 32'd1);
    reset = 1'b0;
    hist.delete();
    #1;
    chk("rstmid_acks",  32'({bus.dm_ack, bus.if_ack}), 32'd0);
    chk("rstmid_en",    32'({bus.mem_wen, bus.mem_ren}), 32'd0);
    chk("rstmid_addr",  bus.mem_addr, 32'd0);
    chk("rstmid_din",   bus.mem_din, 32'd0);
    chk("rstmid_rdata", bus.if_rdata | bus.dm_rdata, 32'd0);
    @(negedge clock);
    #1;
    chk("rstmid_mem20", tb_mem[20], ref_mem[20]);
    bus.dm_req = 1'b0;
    reset = 1'b1;
    run_cycle(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, acks, rd, wen);
    chk("rstmid_idle", 32'(acks), 32'd0);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      run_cycle(($urandom_range(0, 3) != 0), 32'($urandom_range(0, 31)),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1),
                32'($urandom_range(0, 31)), $urandom(), acks, rd, wen);
    end
    for (int i = 0; i < 32; i++) begin
      chk("final_mem", tb_mem[i], ref_mem[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
